cpu_trace_dumper: RTL and testbench

Parametrised run-control and state-dump engine for the single-cycle MIPS core. It replaces fixed-cycle bench dumping with a synthesizable block. It counts cycles and captures a rolling PC/instruction trace. On a cycle limit or a halt instruction, it freezes the CPU and streams out, over a valid/ready port: the trace, then the register file, then a configurable data-memory window, then an end record.

---
 rtl/cpu_trace_dumper.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_cpu_trace_dumper.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_dumper.sv
// -----------------------------------------------------------------------------
// cpu_trace_dumper
//
// Run-control and state-dump engine for the single-cycle MIPS core. It lets
// the CPU run until a committed-cycle limit or a halt instruction. It keeps a
// rolling PC/instruction trace while the CPU runs. When the run ends it freezes
// the CPU and streams the following over a valid/ready port:
//   trace (oldest first) -> register file r0..r31 -> data-memory window -> end
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   enable_i        : starts a run when in IDLE or DONE
//   cycle_limit_i   : commit count that ends the run (latched with enable_i)
//   commit_i        : CPU retired pc_i / instr_i this cycle
//   pc_i, instr_i   : retiring instruction
//   cpu_stall_o     : holds the CPU frozen (1 everywhere except RUN)
//   rf_raddr_o      : register-file read address (combinational read port)
//   rf_rdata_i      : register-file read data
//   dm_raddr_o      : data-memory byte read address (combinational read port)
//   dm_rdata_i      : data-memory read data
//   out_valid_o     : output record valid
//   out_ready_i     : sink accepts output record
//   out_tag_o       : 0 trace, 1 register, 2 memory, 3 end
//   out_addr_o      : PC / register index / byte address / overflow count
//   out_data_o      : instruction / register / memory word / cycle count
//   done_o          : dump complete
// -----------------------------------------------------------------------------
module cpu_trace_dumper #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       TRACE_DEPTH = 8,
    parameter int unsigned       CNT_W       = 16,
    parameter logic [ADDR_W-1:0] DM_BASE     = 32'h0000_0000,
    parameter int unsigned       DM_WORDS    = 9,
    parameter bit                HALT_EN     = 1'b1,
    parameter logic [DATA_W-1:0] HALT_INSTR  = 32'h0000_000C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  cycle_limit_i,
    input  logic              commit_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              cpu_stall_o,
    output logic [4:0]        rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [ADDR_W-1:0] dm_raddr_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_tag_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              done_o
);

    localparam int unsigned PTR_W  = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned MW_W   = $clog2(DM_WORDS + 1);
    localparam int unsigned ENT_W  = ADDR_W + DATA_W;

    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(TRACE_DEPTH);
    localparam logic [MW_W-1:0]   DM_WORDS_L = MW_W'(DM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_REGS,
        S_MEM,
        S_END,
        S_ENDW,   // end record loaded, waiting for its acceptance
        S_DONE
    } state_t;

    state_t            state_q;
    logic              stall_q;
    logic              valid_q;
    logic              done_q;
    logic [1:0]        tag_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  ovf_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] drain_left_q;
    logic [4:0]        reg_idx_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [MW_W-1:0]   mem_left_q;

    // ------------------------------------------------------------------
    // Trace buffer. Written on every commit in RUN. It is read
    // asynchronously at rd_ptr_q. The output record register is the
    // pipeline stage behind the read, so records still go out one per
    // cycle.
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] trace_mem [TRACE_DEPTH];
    logic             trace_we;
    logic [ENT_W-1:0] trace_rd;

    assign trace_we = (state_q == S_RUN) && commit_i;

    always_ff @(posedge clk) begin
        if (trace_we) begin
            trace_mem[wr_ptr_q] <= {pc_i, instr_i};
        end
    end

    assign trace_rd = trace_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Commit bookkeeping (combinational helpers for the RUN state)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  ovf_inc;
    logic [PTR_W-1:0]  wr_ptr_inc;
    logic [FILL_W-1:0] fill_inc;
    logic [PTR_W-1:0]  oldest_ptr;
    logic              halt_hit;
    logic              trigger;
    logic              load;

    assign count_inc  = (&count_q) ? count_q : count_q + CNT_W'(1);
    assign ovf_inc    = (&ovf_q)   ? ovf_q   : ovf_q + CNT_W'(1);
    assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
    assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // The oldest live entry sits fill entries behind the write pointer after
    // this commit. When the buffer is full the low bits of fill are zero. The
    // oldest entry is then the slot the next write would overwrite.
    assign oldest_ptr = wr_ptr_inc - fill_inc[PTR_W-1:0];
    assign halt_hit   = HALT_EN && (instr_i == HALT_INSTR);
    // The limit is compared against the post-increment count, so the
    // triggering commit is itself counted. A zero limit can never be
    // reached that way, so it triggers on the first commit.
    assign trigger    = (limit_q == '0) || (count_inc == limit_q) || halt_hit;

    // The output register may take a new record when empty or when the
    // current one is being accepted this cycle.
    assign load = !valid_q || out_ready_i;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            stall_q      <= 1'b1;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            tag_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            limit_q      <= '0;
            count_q      <= '0;
            ovf_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            drain_left_q <= '0;
            reg_idx_q    <= '0;
            mem_addr_q   <= '0;
            mem_left_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (enable_i) begin
                        limit_q  <= cycle_limit_i;
                        count_q  <= '0;
                        ovf_q    <= '0;
                        wr_ptr_q <= '0;
                        fill_q   <= '0;
                        stall_q  <= 1'b0;
                        done_q   <= 1'b0;
                        state_q  <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (commit_i) begin
                        count_q  <= count_inc;
                        wr_ptr_q <= wr_ptr_inc;
                        fill_q   <= fill_inc;
                        if (fill_q == FILL_FULL) begin
                            ovf_q <= ovf_inc;
                        end
                        if (trigger) begin
                            stall_q      <= 1'b1;
                            rd_ptr_q     <= oldest_ptr;
                            drain_left_q <= fill_inc;
                            state_q      <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (load) begin
                        valid_q      <= 1'b1;
                        tag_q        <= 2'd0;
                        addr_q       <= trace_rd[ENT_W-1:DATA_W];
                        data_q       <= trace_rd[DATA_W-1:0];
                        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                        drain_left_q <= drain_left_q - FILL_W'(1);
                        if (drain_left_q == FILL_W'(1)) begin
                            reg_idx_q <= '0;
                            state_q   <= S_REGS;
                        end
                    end
                end

                S_REGS: begin
                    if (load) begin
                        valid_q   <= 1'b1;
                        tag_q     <= 2'd1;
                        addr_q    <= ADDR_W'(reg_idx_q);
                        // r0 is hard-wired zero in MIPS; the read port may
                        // return anything for it.
                        data_q    <= (reg_idx_q == '0) ? '0 : rf_rdata_i;
                        reg_idx_q <= reg_idx_q + 5'd1;
                        if (reg_idx_q == 5'd31) begin
                            mem_addr_q <= DM_BASE;
                            mem_left_q <= DM_WORDS_L;
                            state_q    <= S_MEM;
                        end
                    end
                end

                S_MEM: begin
                    if (load) begin
                        valid_q    <= 1'b1;
                        tag_q      <= 2'd2;
                        addr_q     <= mem_addr_q;
                        data_q     <= dm_rdata_i;
                        // Plain modular add: the window may wrap past the
                        // top of the address space.
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                        mem_left_q <= mem_left_q - MW_W'(1);
                        if (mem_left_q == MW_W'(1)) begin
                            state_q <= S_END;
                        end
                    end
                end

                S_END: begin
                    if (load) begin
                        valid_q <= 1'b1;
                        tag_q   <= 2'd3;
                        addr_q  <= ADDR_W'(ovf_q);
                        data_q  <= DATA_W'(count_q);
                        state_q <= S_ENDW;
                    end
                end

                S_ENDW: begin
                    if (out_ready_i) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    stall_q <= 1'b1;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall_o = stall_q;
    assign rf_raddr_o  = reg_idx_q;
    assign dm_raddr_o  = mem_addr_q;
    assign out_valid_o = valid_q;
    assign out_tag_o   = tag_q;
    assign out_addr_o  = addr_q;
    assign out_data_o  = data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_cpu_trace_dumper.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cpu_trace_dumper.
// u_dut uses the default parameters. u_wrap uses a memory window that wraps
// past the top of the address space. The expected records come from a small
// model and are queued as the stimulus is driven. A negedge monitor pops and
// compares each accepted record. It also checks that a record is held stable
// while it is stalled.
// -----------------------------------------------------------------------------
module tb_cpu_trace_dumper;

    localparam int CW    = 16;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        int limit;
        int halt_at;    // commit number carrying the halt instruction, 0 = none
        bit rand_rdy;
        bit rf_ones;
        int exp_trace;
        int exp_ovf;
        int exp_cnt;
    } vec_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [1:0]    en_v    = 2'b00;
    logic [CW-1:0] limit   = '0;
    logic          commit  = 1'b0;
    logic [31:0]   pc      = '0;
    logic [31:0]   instr   = '0;
    logic          ready   = 1'b1;
    logic          rf_ones = 1'b0;
    logic          sel     = 1'b0;
    logic          mon_en  = 1'b0;

    logic        d_stall, d_valid, d_done;
    logic [1:0]  d_tag;
    logic [4:0]  d_rf_raddr;
    logic [31:0] d_addr, d_data, d_dm_raddr, d_rf_rdata, d_dm_rdata;
    logic        w_stall, w_valid, w_done;
    logic [1:0]  w_tag;
    logic [4:0]  w_rf_raddr;
    logic [31:0] w_addr, w_data, w_dm_raddr, w_rf_rdata, w_dm_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rec    = 0;
    rec_t exp_q[$];

    always #5 clk = ~clk;

    // Register file and data memory models (combinational read)
    assign d_rf_rdata = rf_ones ? 32'hFFFF_FFFF : (32'hA5A5_0000 | {27'd0, d_rf_raddr});
    assign w_rf_rdata = rf_ones ? 32'hFFFF_FFFF : (32'hA5A5_0000 | {27'd0, w_rf_raddr});
    assign d_dm_rdata = d_dm_raddr ^ 32'h5A5A_A5A5;
    assign w_dm_rdata = w_dm_raddr ^ 32'h5A5A_A5A5;

    cpu_trace_dumper u_dut (
        .clk(clk), .rst(rst), .enable_i(en_v[0]), .cycle_limit_i(limit),
        .commit_i(commit), .pc_i(pc), .instr_i(instr),
        .cpu_stall_o(d_stall), .rf_raddr_o(d_rf_raddr), .rf_rdata_i(d_rf_rdata),
        .dm_raddr_o(d_dm_raddr), .dm_rdata_i(d_dm_rdata),
        .out_valid_o(d_valid), .out_ready_i(ready), .out_tag_o(d_tag),
        .out_addr_o(d_addr), .out_data_o(d_data), .done_o(d_done)
    );

    cpu_trace_dumper #(.DM_BASE(32'hFFFF_FFF8), .DM_WORDS(4)) u_wrap (
        .clk(clk), .rst(rst), .enable_i(en_v[1]), .cycle_limit_i(limit),
        .commit_i(commit), .pc_i(pc), .instr_i(instr),
        .cpu_stall_o(w_stall), .rf_raddr_o(w_rf_raddr), .rf_rdata_i(w_rf_rdata),
        .dm_raddr_o(w_dm_raddr), .dm_rdata_i(w_dm_rdata),
        .out_valid_o(w_valid), .out_ready_i(ready), .out_tag_o(w_tag),
        .out_addr_o(w_addr), .out_data_o(w_data), .done_o(w_done)
    );

    logic        mon_stall, mon_valid, mon_done;
    logic [1:0]  mon_tag;
    logic [31:0] mon_addr, mon_data;
    assign mon_stall = sel ? w_stall : d_stall;
    assign mon_valid = sel ? w_valid : d_valid;
    assign mon_done  = sel ? w_done  : d_done;
    assign mon_tag   = sel ? w_tag   : d_tag;
    assign mon_addr  = sel ? w_addr  : d_addr;
    assign mon_data  = sel ? w_data  : d_data;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Record monitor: one line per accepted record
    rec_t prev_rec;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin : monitor
        rec_t cur;
        rec_t e;
        cur = {mon_tag, mon_addr, mon_data};
        if (!mon_en) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {79'd0, mon_valid}, 80'd1);
                check("hold_record", {14'd0, cur}, {14'd0, prev_rec});
            end
            if (mon_valid && ready) begin
                n_rec++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_record: got tag=%0d addr=%h data=%h, expected none",
                             mon_tag, mon_addr, mon_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("rec %0d: tag=%0d addr=%h data=%h", n_rec, mon_tag, mon_addr, mon_data);
                    check($sformatf("record_%0d", n_rec), {14'd0, cur}, {14'd0, e});
                end
            end
            prev_hold = mon_valid && !ready;
            prev_rec  = cur;
        end
    end

    int   rec_base;
    int   total_exp;
    logic run_rand;

    // Enable, drive commits until the model says the trigger fires, queue
    // the expected dump.
    task automatic start_run(input logic sel_i, input vec_t v);
        int          cnt;
        logic        trig;
        rec_t        tq[$];
        logic [31:0] a;
        logic [31:0] dm_base_l;
        int          dm_words_l;
        sel        = sel_i;
        rf_ones    = v.rf_ones;
        run_rand   = v.rand_rdy;
        exp_q.delete();
        rec_base   = n_rec;
        mon_en     = 1'b1;
        dm_base_l  = sel_i ? 32'hFFFF_FFF8 : 32'h0;
        dm_words_l = sel_i ? 4 : 9;
        @(posedge clk); #1;
        ready = 1'b1;
        limit = CW'(v.limit);
        en_v[sel_i] = 1'b1;
        @(posedge clk); #1;
        en_v = 2'b00;
        cnt  = 0;
        trig = 1'b0;
        while (!trig && cnt < 200) begin
            check("stall_in_run", {79'd0, mon_stall}, 80'd0);
            commit = 1'b1;
            pc     = 32'h3000 + 32'(4 * cnt);
            instr  = (cnt + 1 == v.halt_at) ? 32'h0000_000C : 32'h2000_0000 + 32'(cnt);
            cnt++;
            tq.push_back({2'd0, pc, instr});
            if (tq.size() > DEPTH) void'(tq.pop_front());
            trig = (v.limit == 0) || (cnt == v.limit) || (cnt == v.halt_at);
            @(posedge clk); #1;
        end
        commit = 1'b0;
        check("stall_after_trigger", {79'd0, mon_stall}, 80'd1);
        foreach (tq[i]) exp_q.push_back(tq[i]);
        for (int r = 0; r < 32; r++) begin
            a = (r == 0) ? 32'h0 : (v.rf_ones ? 32'hFFFF_FFFF : (32'hA5A5_0000 | 32'(r)));
            exp_q.push_back({2'd1, 32'(r), a});
        end
        for (int k = 0; k < dm_words_l; k++) begin
            a = dm_base_l + 32'(4 * k);
            exp_q.push_back({2'd2, a, a ^ 32'h5A5A_A5A5});
        end
        exp_q.push_back({2'd3, 32'(v.exp_ovf), 32'(v.exp_cnt)});
        total_exp = v.exp_trace + 32 + dm_words_l + 1;
    endtask

    task automatic finish_run();
        int cyc;
        cyc = 0;
        while (!mon_done && cyc < 3000) begin
            @(posedge clk); #1;
            ready = run_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            cyc++;
        end
        check("done_reached", {79'd0, mon_done}, 80'd1);
        check("record_count", 80'(n_rec - rec_base), 80'(total_exp));
        check("queue_empty", 80'(exp_q.size()), 80'd0);
        check("stall_in_done", {79'd0, mon_stall}, 80'd1);
        check("valid_in_done", {79'd0, mon_valid}, 80'd0);
        ready = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin : main
        int cyc;
        vecs[0] = '{5,   0, 1'b0, 1'b0, 5, 0,  5};   // limit run
        vecs[1] = '{12,  0, 1'b0, 1'b0, 8, 4,  12};  // trace overflow
        vecs[2] = '{100, 3, 1'b0, 1'b1, 3, 0,  3};   // halt, r0 forced to 0
        vecs[3] = '{5,   0, 1'b1, 1'b0, 5, 0,  5};   // backpressure
        vecs[4] = '{3,   3, 1'b1, 1'b0, 3, 0,  3};   // limit and halt together
        vecs[5] = '{20,  0, 1'b1, 1'b0, 8, 12, 20};  // overflow + backpressure

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall",    {79'd0, d_stall}, 80'd1);
        check("rst_valid",    {79'd0, d_valid}, 80'd0);
        check("rst_done",     {79'd0, d_done}, 80'd0);
        check("rst_tag",      {78'd0, d_tag}, 80'd0);
        check("rst_addr",     {48'd0, d_addr}, 80'd0);
        check("rst_data",     {48'd0, d_data}, 80'd0);
        check("rst_rf_raddr", {75'd0, d_rf_raddr}, 80'd0);
        check("rst_dm_raddr", {48'd0, d_dm_raddr}, 80'd0);
        check("rst_wrap_stall", {79'd0, w_stall}, 80'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: limit=%0d halt_at=%0d rand_ready=%0d", i,
                     vecs[i].limit, vecs[i].halt_at, vecs[i].rand_rdy);
            start_run(1'b0, vecs[i]);
            finish_run();
        end

        // Reset in the middle of the register dump
        $display("sequence: reset during register index 10");
        start_run(1'b0, vecs[0]);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(d_valid && d_tag == 2'd1 && d_addr == 32'd10) && cyc < 500);
        check("reached_reg10", 80'(cyc < 500), 80'd1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", {79'd0, d_valid}, 80'd0);
        check("midrst_done",  {79'd0, d_done}, 80'd0);
        check("midrst_stall", {79'd0, d_stall}, 80'd1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("midrst_quiet", {79'd0, d_valid}, 80'd0);
        end
        start_run(1'b0, vecs[0]);
        finish_run();

        // Wrapping memory window with a zero limit
        $display("sequence: wrap window, limit 0");
        start_run(1'b1, '{0, 0, 1'b0, 1'b0, 1, 0, 1});
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
